// File: rtl/hs32_mem_arb_pkg.sv
// Shared types for the hs32 two-master memory arbiter: FSM states and master-select codes.
package hs32_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_F = 2'd1,
      BUSY_E = 2'd2
   } arbState_t;

   localparam logic SEL_F = 1'b0;
   localparam logic SEL_E = 1'b1;

endpackage

// File: rtl/hs32_mem_arb_if.sv
// Bus interfaces around the hs32 arbiter: fetch and execute request ports, external memory bus.
interface hs32_fetch_if;
   logic [31:0] addr_f;
   logic        reqm_f;
   logic [31:0] dtr_f;
   logic        ackm_f;

   modport master (output addr_f, reqm_f, input dtr_f, ackm_f);
   modport slave  (input addr_f, reqm_f, output dtr_f, ackm_f);
endinterface

interface hs32_exec_if;
   logic [31:0] addr_e;
   logic [31:0] dtw_e;
   logic        rw_e;
   logic        reqm_e;
   logic [31:0] dtr_e;
   logic        ackm_e;

   modport master (output addr_e, dtw_e, rw_e, reqm_e, input dtr_e, ackm_e);
   modport slave  (input addr_e, dtw_e, rw_e, reqm_e, output dtr_e, ackm_e);
endinterface

interface hs32_mem_if;
   logic [31:0] mem_addr;
   logic [31:0] mem_dtw;
   logic        mem_rw;
   logic        mem_stb;
   logic [31:0] mem_dtr;
   logic        mem_ack;

   modport master (output mem_addr, mem_dtw, mem_rw, mem_stb, input mem_dtr, mem_ack);
   modport slave  (input mem_addr, mem_dtw, mem_rw, mem_stb, output mem_dtr, mem_ack);
endinterface

// File: rtl/hs32_mem_arb.sv
// Fetch/execute to single-memory arbiter with execute priority and registered ack pulses.
// Optional fetch starvation guard enabled by defining HS32_ARB_FAIR_EN.
module hs32_mem_arb
   import hs32_arb_pkg::*;
#(
   parameter int FAIR_LIMIT = 4
) (
   input logic           clk,
   input logic           reset_n,
   hs32_fetch_if.slave   fch,
   hs32_exec_if.slave    exe,
   hs32_mem_if.master    mem
);

   arbState_t state;
   logic      suppress;
   logic      grantValid;
   logic      grantSel;
   logic      fairForce;

`ifdef HS32_ARB_FAIR_EN
   localparam int CW = $clog2(FAIR_LIMIT + 1);
   logic [CW-1:0] fairCnt;

   assign fairForce = fch.reqm_f && (fairCnt >= CW'(FAIR_LIMIT));

   // Counts execute grants that overtook a waiting fetch; any fetch grant clears it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fairCnt <= '0;
      end else if (state == IDLE && grantValid) begin
         if (grantSel == SEL_F) begin
            fairCnt <= '0;
         end else if (fch.reqm_f && (fairCnt < CW'(FAIR_LIMIT))) begin
            fairCnt <= fairCnt + 1'b1;
         end
      end
   end
`else
   // Strict execute priority: a fetch grant is never forced.
   assign fairForce = (FAIR_LIMIT < 0);
`endif

   always_comb begin
      grantValid = !suppress && (exe.reqm_e || fch.reqm_f);
      grantSel   = (exe.reqm_e && !fairForce) ? SEL_E : SEL_F;
   end

   // Suppress blocks arbitration in the ack cycle so a master that has not yet
   // dropped its request is not granted a second time.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         suppress     <= 1'b0;
         mem.mem_addr <= '0;
         mem.mem_dtw  <= '0;
         mem.mem_rw   <= 1'b0;
         mem.mem_stb  <= 1'b0;
         fch.dtr_f    <= '0;
         fch.ackm_f   <= 1'b0;
         exe.dtr_e    <= '0;
         exe.ackm_e   <= 1'b0;
      end else begin
         fch.ackm_f <= 1'b0;
         exe.ackm_e <= 1'b0;
         suppress   <= 1'b0;
         case (state)
            IDLE: begin
               if (grantValid) begin
                  mem.mem_stb <= 1'b1;
                  if (grantSel == SEL_E) begin
                     mem.mem_addr <= exe.addr_e;
                     mem.mem_dtw  <= exe.dtw_e;
                     mem.mem_rw   <= exe.rw_e;
                     state        <= BUSY_E;
                  end else begin
                     mem.mem_addr <= fch.addr_f;
                     mem.mem_rw   <= 1'b0;
                     state        <= BUSY_F;
                  end
               end
            end
            BUSY_F: begin
               if (mem.mem_ack) begin
                  mem.mem_stb <= 1'b0;
                  state       <= IDLE;
                  // A flushed fetch still finishes the bus cycle but gets no data.
                  if (fch.reqm_f) begin
                     fch.dtr_f  <= mem.mem_dtr;
                     fch.ackm_f <= 1'b1;
                     suppress   <= 1'b1;
                  end
               end
            end
            BUSY_E: begin
               if (mem.mem_ack) begin
                  mem.mem_stb <= 1'b0;
                  state       <= IDLE;
                  exe.ackm_e  <= 1'b1;
                  suppress    <= 1'b1;
                  if (!mem.mem_rw) begin
                     exe.dtr_e <= mem.mem_dtr;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hs32_mem_arb.sv
// Randomised self-checking bench for hs32_mem_arb; expectations come from a transaction-level
// memory/ordering model. Fairness expectations follow HS32_ARB_FAIR_EN.
module tb_hs32_mem_arb;

   typedef struct { int cyc; bit isE; logic [31:0] data; } ackRec_t;
   typedef struct { int cyc; logic [31:0] addr; bit rw; logic [31:0] dtw; } busRec_t;
   typedef struct { bit isE; logic [31:0] addr; bit rw; logic [31:0] dtw; } expTxn_t;

   logic clk = 1'b0;
   logic reset_n;

   hs32_fetch_if fch();
   hs32_exec_if  exe();
   hs32_mem_if   mem();

   hs32_mem_arb #(.FAIR_LIMIT(4)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .fch     (fch),
      .exe     (exe),
      .mem     (mem)
   );

   always #5 clk = ~clk;

   ackRec_t     ackLog[$];
   busRec_t     busLog[$];
   logic [31:0] refMem   [logic [31:0]];
   logic [31:0] memStore [logic [31:0]];
   logic [31:0] refDtrE = '0;
   int          vectors = 0;
   int          miscompares = 0;
   int          cycle = 0;
   int          overlap = 0;
   int          memLat = 1;
   bit          holdE = 1'b0;
   bit          prevStb = 1'b0;

   function automatic logic [31:0] dfltData(input logic [31:0] a);
      return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
   endfunction

   function automatic logic [31:0] refRead(input logic [31:0] a);
      return refMem.exists(a) ? refMem[a] : dfltData(a);
   endfunction

   function automatic logic [31:0] pickAddr();
      return 32'h0000_8000 + 32'($urandom_range(0, 15)) * 32'd4;
   endfunction

   // External memory: acks memLat cycles after strobe (0 = random 1..4), abandons on reset.
   initial begin
      int lat;
      bit alive;
      logic [31:0] a;
      mem.mem_ack = 1'b0;
      mem.mem_dtr = '0;
      forever begin
         @(negedge clk);
         mem.mem_ack = 1'b0;
         mem.mem_dtr = $urandom;
         if (reset_n && mem.mem_stb) begin
            lat   = (memLat == 0) ? $urandom_range(1, 4) : memLat;
            alive = 1'b1;
            for (int i = 0; i < lat; i++) begin
               @(negedge clk);
               mem.mem_dtr = $urandom;
               if (!reset_n || !mem.mem_stb) begin
                  alive = 1'b0;
                  break;
               end
            end
            if (alive) begin
               a = mem.mem_addr;
               if (mem.mem_rw) memStore[a] = mem.mem_dtw;
               else mem.mem_dtr = memStore.exists(a) ? memStore[a] : dfltData(a);
               mem.mem_ack = 1'b1;
            end
         end
      end
   end

   assert property (@(posedge clk) disable iff (!reset_n) $fell(exe.reqm_e) |-> exe.ackm_e)
      else $error("[TB] execute request dropped before its ack");

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic stepCycle();
      @(negedge clk);
      cycle++;
      if (fch.ackm_f && exe.ackm_e) overlap++;
      if (mem.mem_stb && !prevStb) busLog.push_back('{cycle, mem.mem_addr, mem.mem_rw, mem.mem_dtw});
      prevStb = mem.mem_stb;
      if (exe.ackm_e) begin
         ackLog.push_back('{cycle, 1'b1, exe.dtr_e});
         if (!holdE) exe.reqm_e = 1'b0;
      end
      if (fch.ackm_f) begin
         ackLog.push_back('{cycle, 1'b0, fch.dtr_f});
         fch.reqm_f = 1'b0;
      end
   endtask

   task automatic clearLogs();
      ackLog.delete();
      busLog.delete();
      overlap = 0;
   endtask

   task automatic runUntil(input int nAcks, input int budget, output bit timedOut);
      int n = 0;
      while (ackLog.size() < nAcks && n < budget) begin
         stepCycle();
         n++;
      end
      timedOut = (ackLog.size() < nAcks);
      repeat (3) stepCycle();
   endtask

   task automatic applyStimulus();
      reset_n    = 1'b0;
      fch.addr_f = '0;
      fch.reqm_f = 1'b0;
      exe.addr_e = '0;
      exe.dtw_e  = '0;
      exe.rw_e   = 1'b0;
      exe.reqm_e = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] obs[8];
      string names[8] = '{"mem_addr", "mem_dtw", "mem_rw", "mem_stb", "dtr_f", "ackm_f", "dtr_e", "ackm_e"};
      applyStimulus();
      repeat (2) stepCycle();
      obs = '{mem.mem_addr, mem.mem_dtw, 32'(mem.mem_rw), 32'(mem.mem_stb),
              fch.dtr_f, 32'(fch.ackm_f), exe.dtr_e, 32'(exe.ackm_e)};
      for (int i = 0; i < 8; i++) begin
         vectors++;
         if (obs[i] !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_%s: got %h want 00000000", names[i], obs[i]);
         end
      end
      reset_n = 1'b1;
      repeat (2) stepCycle();
   endtask

   task automatic test_fetch_only();
      int t0;
      bit to;
      clearLogs();
      memLat = 2;
      memStore[32'h100] = 32'hDEADBEEF;
      refMem[32'h100]   = 32'hDEADBEEF;
      fch.addr_f = 32'h100;
      fch.reqm_f = 1'b1;
      t0 = cycle;
      runUntil(1, 30, to);
      vectors++;
      if (to) begin miscompares++; $display("[TB] FAIL fetch_timeout: got no ackm_f want ackm_f"); end
      vectors++;
      if (busLog.size() != 1) begin miscompares++; $display("[TB] FAIL fetch_bus_count: got %0d want 1", busLog.size()); end
      vectors++;
      if (ackLog.size() != 1) begin miscompares++; $display("[TB] FAIL fetch_ack_count: got %0d want 1", ackLog.size()); end
      if (busLog.size() >= 1) begin
         vectors++;
         if (busLog[0].addr !== 32'h100 || busLog[0].rw !== 1'b0 || busLog[0].cyc != t0 + 1) begin
            miscompares++;
            $display("[TB] FAIL fetch_bus: got addr %h rw %b cyc %0d want addr 00000100 rw 0 cyc %0d",
                     busLog[0].addr, busLog[0].rw, busLog[0].cyc, t0 + 1);
         end
      end
      if (ackLog.size() >= 1) begin
         vectors++;
         if (ackLog[0].isE !== 1'b0 || ackLog[0].data !== 32'hDEADBEEF || ackLog[0].cyc != t0 + 4) begin
            miscompares++;
            $display("[TB] FAIL fetch_ack: got isE %b data %h cyc %0d want isE 0 data deadbeef cyc %0d",
                     ackLog[0].isE, ackLog[0].data, ackLog[0].cyc, t0 + 4);
         end
      end
   endtask

   task automatic test_exec_write();
      int t0;
      bit to;
      clearLogs();
      memLat = 3;
      exe.addr_e = 32'h2000;
      exe.dtw_e  = 32'h12345678;
      exe.rw_e   = 1'b1;
      exe.reqm_e = 1'b1;
      t0 = cycle;
      stepCycle();
      stepCycle();
      vectors++;
      if (mem.mem_stb !== 1'b1 || mem.mem_rw !== 1'b1 || mem.mem_dtw !== 32'h12345678 || mem.mem_addr !== 32'h2000) begin
         miscompares++;
         $display("[TB] FAIL exec_wr_bus: got stb %b rw %b addr %h dtw %h want 1 1 00002000 12345678",
                  mem.mem_stb, mem.mem_rw, mem.mem_addr, mem.mem_dtw);
      end
      runUntil(1, 30, to);
      refMem[32'h2000] = 32'h12345678;
      vectors++;
      if (to || ackLog.size() != 1) begin
         miscompares++;
         $display("[TB] FAIL exec_wr_ack_count: got %0d want 1", ackLog.size());
      end else begin
         vectors++;
         if (ackLog[0].isE !== 1'b1 || ackLog[0].data !== refDtrE || ackLog[0].cyc != t0 + 5) begin
            miscompares++;
            $display("[TB] FAIL exec_wr_ack: got isE %b dtr_e %h cyc %0d want 1 %h %0d",
                     ackLog[0].isE, ackLog[0].data, ackLog[0].cyc, refDtrE, t0 + 5);
         end
      end
      vectors++;
      if (!memStore.exists(32'h2000) || memStore[32'h2000] !== 32'h12345678) begin
         miscompares++;
         $display("[TB] FAIL exec_wr_mem: got missing/other want 12345678");
      end
   endtask

   task automatic test_contention();
      logic [31:0] ae, af, expE, expF;
      bit to;
      clearLogs();
      memLat = 0;
      ae = pickAddr();
      af = pickAddr();
      exe.addr_e = ae;
      exe.rw_e   = 1'b0;
      exe.dtw_e  = $urandom;
      fch.addr_f = af;
      exe.reqm_e = 1'b1;
      fch.reqm_f = 1'b1;
      expE = refRead(ae);
      expF = refRead(af);
      refDtrE = expE;
      runUntil(2, 60, to);
      vectors++;
      if (to || ackLog.size() != 2 || busLog.size() != 2) begin
         miscompares++;
         $display("[TB] FAIL contention_count: got acks %0d bus %0d want 2 2", ackLog.size(), busLog.size());
      end else begin
         vectors++;
         if (ackLog[0].isE !== 1'b1 || ackLog[0].data !== expE || ackLog[1].isE !== 1'b0 || ackLog[1].data !== expF) begin
            miscompares++;
            $display("[TB] FAIL contention_data: got %b:%h %b:%h want 1:%h 0:%h",
                     ackLog[0].isE, ackLog[0].data, ackLog[1].isE, ackLog[1].data, expE, expF);
         end
         vectors++;
         if (busLog[0].addr !== ae || busLog[1].addr !== af || busLog[1].cyc != ackLog[0].cyc + 2) begin
            miscompares++;
            $display("[TB] FAIL contention_order: got %h %h cyc %0d want %h %h cyc %0d",
                     busLog[0].addr, busLog[1].addr, busLog[1].cyc, ae, af, ackLog[0].cyc + 2);
         end
      end
      vectors++;
      if (overlap != 0) begin miscompares++; $display("[TB] FAIL contention_overlap: got %0d want 0", overlap); end
   endtask

   task automatic test_flush();
      bit to;
      clearLogs();
      memLat = 4;
      fch.addr_f = 32'h300;
      fch.reqm_f = 1'b1;
      stepCycle();
      stepCycle();
      fch.reqm_f = 1'b0;
      stepCycle();
      vectors++;
      if (mem.mem_stb !== 1'b1) begin miscompares++; $display("[TB] FAIL flush_stb_held: got %b want 1", mem.mem_stb); end
      repeat (8) stepCycle();
      vectors++;
      if (ackLog.size() != 0 || busLog.size() != 1 || mem.mem_stb !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL flush_no_ack: got acks %0d bus %0d stb %b want 0 1 0", ackLog.size(), busLog.size(), mem.mem_stb);
      end
      clearLogs();
      memLat = 1;
      exe.addr_e = 32'h700;
      exe.rw_e   = 1'b0;
      exe.reqm_e = 1'b1;
      refDtrE = refRead(32'h700);
      runUntil(1, 20, to);
      vectors++;
      if (to || ackLog.size() != 1 || ackLog[0].data !== refDtrE) begin
         miscompares++;
         $display("[TB] FAIL flush_recover: got acks %0d want 1 with data %h", ackLog.size(), refDtrE);
      end
   endtask

   task automatic test_fairness();
      int n = 0;
      int nE = 0;
      int fIdx = -1;
      int wantIdx;
      bit gotF = 1'b0;
      clearLogs();
      memLat = 1;
      holdE = 1'b1;
      exe.addr_e = 32'h400;
      exe.rw_e   = 1'b0;
      fch.addr_f = 32'h500;
      exe.reqm_e = 1'b1;
      fch.reqm_f = 1'b1;
      while (!(gotF && nE >= 5) && n < 200) begin
         stepCycle();
         n++;
         nE = 0;
         gotF = 1'b0;
         foreach (ackLog[k]) begin
            if (ackLog[k].isE) nE++;
            else gotF = 1'b1;
         end
         if (holdE && nE >= 5) begin
            holdE = 1'b0;
            exe.reqm_e = 1'b0;
         end
      end
      holdE = 1'b0;
      exe.reqm_e = 1'b0;
      repeat (3) stepCycle();
      foreach (busLog[k]) if (fIdx < 0 && busLog[k].addr == 32'h500) fIdx = k;
`ifdef HS32_ARB_FAIR_EN
      wantIdx = 4;
`else
      wantIdx = 5;
`endif
      vectors++;
      if (fIdx != wantIdx || busLog.size() != 6) begin
         miscompares++;
         $display("[TB] FAIL fairness_grant: got fetch at grant %0d of %0d want %0d of 6", fIdx, busLog.size(), wantIdx);
      end
      refDtrE = refRead(32'h400);
      foreach (ackLog[k]) begin
         vectors++;
         if (ackLog[k].data !== (ackLog[k].isE ? refDtrE : refRead(32'h500))) begin
            miscompares++;
            $display("[TB] FAIL fairness_data[%0d]: got %h want %h", k, ackLog[k].data,
                     ackLog[k].isE ? refDtrE : refRead(32'h500));
         end
      end
   endtask

   task automatic test_reset_mid();
      int t0;
      bit to;
      clearLogs();
      memLat = 8;
      exe.addr_e = 32'h600;
      exe.dtw_e  = $urandom;
      exe.rw_e   = 1'b1;
      exe.reqm_e = 1'b1;
      stepCycle();
      stepCycle();
      vectors++;
      if (mem.mem_stb !== 1'b1 || mem.mem_rw !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL rstmid_busy: got stb %b rw %b want 1 1", mem.mem_stb, mem.mem_rw);
      end
      reset_n = 1'b0;
      exe.reqm_e = 1'b0;
      #1;
      vectors++;
      if (mem.mem_stb !== 1'b0 || mem.mem_rw !== 1'b0 || exe.ackm_e !== 1'b0 || fch.ackm_f !== 1'b0 || mem.mem_addr !== 32'h0) begin
         miscompares++;
         $display("[TB] FAIL rstmid_clear: got stb %b rw %b acks %b%b addr %h want 0 0 00 00000000",
                  mem.mem_stb, mem.mem_rw, exe.ackm_e, fch.ackm_f, mem.mem_addr);
      end
      repeat (3) stepCycle();
      reset_n = 1'b1;
      refDtrE = '0;
      repeat (12) stepCycle();
      vectors++;
      if (memStore.exists(32'h600) || ackLog.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL rstmid_abandon: got write/ack after reset want none");
      end
      clearLogs();
      memLat = 1;
      exe.rw_e   = 1'b0;
      exe.reqm_e = 1'b1;
      t0 = cycle;
      runUntil(1, 20, to);
      refDtrE = dfltData(32'h600);
      vectors++;
      if (to || ackLog.size() != 1 || ackLog[0].cyc != t0 + 3 || ackLog[0].data !== refDtrE) begin
         miscompares++;
         $display("[TB] FAIL rstmid_after: got acks %0d want 1 at cyc %0d with %h", ackLog.size(), t0 + 3, refDtrE);
      end
   endtask

   task automatic test_random_mix();
      expTxn_t     exp[$];
      logic [31:0] expData[$];
      expTxn_t     te, tf;
      int          p;
      bit          to;
      for (int it = 0; it < 40; it++) begin
         clearLogs();
         exp.delete();
         expData.delete();
         memLat = 0;
         p  = $urandom_range(0, 4);
         te = '{1'b1, pickAddr(), 1'($urandom_range(0, 1)), $urandom};
         tf = '{1'b0, pickAddr(), 1'b0, 32'h0};
         case (p)
            0: exp.push_back(tf);
            1: exp.push_back(te);
            2, 3: begin exp.push_back(te); exp.push_back(tf); end
            default: begin exp.push_back(tf); exp.push_back(te); end
         endcase
         foreach (exp[k]) begin
            if (exp[k].isE && exp[k].rw) begin
               refMem[exp[k].addr] = exp[k].dtw;
               expData.push_back(refDtrE);
            end else begin
               expData.push_back(refRead(exp[k].addr));
               if (exp[k].isE) refDtrE = expData[k];
            end
         end
         exe.addr_e = te.addr;
         exe.rw_e   = te.rw;
         exe.dtw_e  = te.dtw;
         fch.addr_f = tf.addr;
         if (p != 0 && p != 4) exe.reqm_e = 1'b1;
         if (p == 0 || p == 2 || p == 4) fch.reqm_f = 1'b1;
         if (p == 3) begin stepCycle(); fch.reqm_f = 1'b1; end
         if (p == 4) begin stepCycle(); exe.reqm_e = 1'b1; end
         runUntil(exp.size(), 60, to);
         vectors++;
         if (to || ackLog.size() != exp.size() || busLog.size() != exp.size() || overlap != 0) begin
            miscompares++;
            $display("[TB] FAIL rand%0d_count: got acks %0d bus %0d overlap %0d want %0d %0d 0",
                     it, ackLog.size(), busLog.size(), overlap, exp.size(), exp.size());
         end
         for (int k = 0; k < exp.size() && k < ackLog.size() && k < busLog.size(); k++) begin
            vectors++;
            if (busLog[k].addr !== exp[k].addr || busLog[k].rw !== exp[k].rw ||
                (exp[k].rw && busLog[k].dtw !== exp[k].dtw) ||
                ackLog[k].isE !== exp[k].isE || ackLog[k].data !== expData[k]) begin
               miscompares++;
               $display("[TB] FAIL rand%0d_txn%0d: got addr %h rw %b isE %b data %h want addr %h rw %b isE %b data %h",
                        it, k, busLog[k].addr, busLog[k].rw, ackLog[k].isE, ackLog[k].data,
                        exp[k].addr, exp[k].rw, exp[k].isE, expData[k]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_fetch_only();
      test_exec_write();
      test_contention();
      test_flush();
      test_fairness();
      test_reset_mid();
      test_random_mix();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
